alu_input_conditioner: RTL

- Upstream stage of alu2bit_top: conditions raw board inputs (4 push-buttons, 2 slide switches) before they drive the ALU operand and select lines.
- Per bit: 2-flop synchronizer, then a counter-based debouncer.
- Outputs are clean, stable copies of the inputs, plus one-cycle press pulses and a change strobe for downstream display/logging logic.

---
 rtl/alu_input_conditioner_pkg.sv | 19 +
 rtl/debounce_bit.sv | 55 +++++
 rtl/alu_input_conditioner.sv | 61 ++++++
 3 files changed

// File: rtl/alu_input_conditioner_pkg.sv
// Shared constants and helpers for the ALU board-input conditioner.
package alu_input_conditioner_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT = 500000;
  localparam int unsigned NUM_BTN          = 4;
  localparam int unsigned NUM_SW           = 2;

  // Ceiling log2, used to size the debounce counter.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result = 0;
    int unsigned span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchronizer, counter debouncer, flip strobes.
module debounce_bit
  import alu_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic CLK,
  input  logic RESET,
  input  logic raw,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
    $error("debounce_bit: DEBOUNCE_CYCLES must be >= 2");
  end

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             flip;

  // Flip happens on the coming edge: enough consecutive disagreeing samples.
  assign flip = (s2 != q) && (cnt == CNT_LAST);

  // rise/fall are strobes from registered state only; the parent registers
  // them so its pulses line up with the cycle q shows the new value.
  assign rise = flip && s2;
  assign fall = flip && !s2;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      q   <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == q) begin
        cnt <= '0;
      end else if (flip) begin
        q   <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_input_conditioner.sv
// Debounces the board buttons/switches feeding alu2bit_top; adds press and change pulses.
module alu_input_conditioner
  import alu_input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [0:3]  BUTTONS,
  input  logic [1:0]  SWITCHES,
  output logic [0:3]  BTN_CLEAN,
  output logic [1:0]  SW_CLEAN,
  output logic [0:3]  BTN_RISE,
  output logic        CHANGED
);

  localparam int unsigned NUM_IN = NUM_BTN + NUM_SW;

  logic [NUM_IN-1:0] raw;
  logic [NUM_IN-1:0] q;
  logic [NUM_IN-1:0] rise;
  logic [NUM_IN-1:0] fall;
  logic [0:3]        btn_rise_c;

  // Flat bit index: buttons first, then switches.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn_map
    assign raw[i]        = BUTTONS[i];
    assign BTN_CLEAN[i]  = q[i];
    assign btn_rise_c[i] = rise[i];
  end

  for (genvar j = 0; j < NUM_SW; j++) begin : g_sw_map
    assign raw[NUM_BTN + j] = SWITCHES[j];
    assign SW_CLEAN[j]      = q[NUM_BTN + j];
  end

  for (genvar n = 0; n < NUM_IN; n++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .CLK  (CLK),
      .RESET(RESET),
      .raw  (raw[n]),
      .q    (q[n]),
      .rise (rise[n]),
      .fall (fall[n])
    );
  end

  // Pulses registered on the same edge that updates q.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      BTN_RISE <= '0;
      CHANGED  <= 1'b0;
    end else begin
      BTN_RISE <= btn_rise_c;
      CHANGED  <= |(rise | fall);
    end
  end

endmodule
